// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Purpose: Types and constants shared by the data cache and the backing RAM
//          on the cache/RAM link.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package mem_pkg;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module : mem_word_array
// Purpose: Synchronous single-port word array. Writes one word per cycle;
//          reads a whole aligned 4-word line into a registered output.
// Ports  : clk      clock
//          rstn     synchronous active-low reset (clears the read register only)
//          we_i     write enable, waddr_i word index, wdata_i store data
//          re_i     line read enable, rline_i line index
//          rline_o  registered line, word i at [32*i+31:32*i]
// Rev    : 1.0  initial release
// ============================================================================
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-3:0]     rline_i,
  output logic [LINE_W-1:0] rline_o
);
  // Storage contents survive reset.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // One read register per word lane; the lane number supplies the low
  // two bits of the word index so the line is always aligned.
  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic [WORD_W-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        lane_q <= '0;
      end else if (re_i) begin
        lane_q <= mem_q[{rline_i, LANE}];
      end
    end

    assign rline_o[WORD_W*i +: WORD_W] = lane_q;
  end
endmodule
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module : main_memory
// Purpose: Fixed-latency backing RAM serving cache line refills (128-bit
//          reads) and write-through word stores.
// Ports  : clk          clock
//          rstn         synchronous active-low reset
//          ireq_valid   request strobe; ireq_write selects word write
//          iaddr        byte address; iwrite_data store data
//          oready       request can be accepted this cycle
//          oresp_valid  one-cycle completion pulse
//          oread_line   refill line, held until the next read completes
// Rev    : 1.0  initial release
// ============================================================================
module main_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ireq_valid,
  input  logic              ireq_write,
  input  logic [31:0]       iaddr,
  input  logic [31:0]       iwrite_data,
  output logic              oready,
  output logic              oresp_valid,
  output logic [LINE_W-1:0] oread_line
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              write_q;
  logic [AW-1:0]     word_idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              oready_q;
  logic              oresp_valid_q;

  // Address bits outside the array window are aliased away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[31:AW+2], iaddr[1:0]};

  // The access happens on the last BUSY edge. Gating with rstn makes a
  // reset on that very edge abort the store as well.
  logic access_now;
  assign access_now = (state_q == BUSY) && (cnt_q == '0) && rstn;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      word_idx_q    <= '0;
      wdata_q       <= '0;
      oready_q      <= 1'b1;
      oresp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ireq_valid) begin
            write_q    <= ireq_write;
            word_idx_q <= iaddr[AW+1:2];
            wdata_q    <= iwrite_data;
            cnt_q      <= CW'(LATENCY - 1);
            oready_q   <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            oresp_valid_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          oresp_valid_q <= 1'b0;
          oready_q      <= 1'b1;
          state_q       <= IDLE;
        end
        default: begin
          oresp_valid_q <= 1'b0;
          oready_q      <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rstn   (rstn),
    .we_i   (access_now && write_q),
    .waddr_i(word_idx_q),
    .wdata_i(wdata_q),
    .re_i   (access_now && !write_q),
    .rline_i(word_idx_q[AW-1:2]),
    .rline_o(oread_line)
  );

  assign oready      = oready_q;
  assign oresp_valid = oresp_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module : tb_main_memory
// Purpose: Scoreboard bench for main_memory, one instance at latency 4 and
//          one at latency 1, driven with directed and random requests.
// Rev    : 1.0  initial release
// ============================================================================
module tb_main_memory;
  localparam int DW   = 1024;
  localparam int LATA = 4;
  localparam int LATB = 1;

  typedef struct {
    int           due;
    bit           w;
    logic [127:0] line;
    logic [127:0] mask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rstn [2];
  logic         vld  [2];
  logic         wr   [2];
  logic [31:0]  addr [2];
  logic [31:0]  wd   [2];
  logic         rdy  [2];
  logic         rv   [2];
  logic [127:0] line [2];

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: plain word array plus "has been written" flags.
  logic [31:0] mem_m [2][DW];
  bit          known [2][DW];

  main_memory #(.DEPTH_WORDS(DW), .LATENCY(LATA)) u_dut_a (
    .clk(clk), .rstn(rstn[0]), .ireq_valid(vld[0]), .ireq_write(wr[0]),
    .iaddr(addr[0]), .iwrite_data(wd[0]), .oready(rdy[0]),
    .oresp_valid(rv[0]), .oread_line(line[0]));

  main_memory #(.DEPTH_WORDS(DW), .LATENCY(LATB)) u_dut_b (
    .clk(clk), .rstn(rstn[1]), .ireq_valid(vld[1]), .ireq_write(wr[1]),
    .iaddr(addr[1]), .iwrite_data(wd[1]), .oready(rdy[1]),
    .oresp_valid(rv[1]), .oread_line(line[1]));

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_wr(input int d, input logic [31:0] a, input logic [31:0] data);
    int idx;
    idx = int'((a >> 2) % DW);
    mem_m[d][idx] = data;
    known[d][idx] = 1'b1;
  endtask

  task automatic exp_line(input int d, input logic [31:0] a,
                          output logic [127:0] l, output logic [127:0] m);
    int base;
    base = int'((a >> 2) % DW) & ~3;
    for (int i = 0; i < 4; i++) begin
      l[32*i +: 32] = mem_m[d][base + i];
      m[32*i +: 32] = known[d][base + i] ? 32'hFFFF_FFFF : 32'h0;
    end
  endtask

  // Called at a negedge. Returns at the negedge after acceptance; acc is the
  // index of the acceptance clock edge.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input bit hold, input bit commit,
                       output int acc);
    exp_t e;
    int   g;
    int   lat;
    lat = (d == 0) ? LATA : LATB;
    vld[d] = 1'b1; wr[d] = w; addr[d] = a; wd[d] = data;
    g = 0;
    while (!rdy[d] && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!rdy[d]) begin
      check("ready timeout", 128'd0, 128'd1);
      vld[d] = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc + 1;
    e.due = acc + lat;
    e.w   = w;
    if (w) begin
      e.line = '0;
      e.mask = '0;
      if (commit) model_wr(d, a, data);
    end else begin
      exp_line(d, a, e.line, e.mask);
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    check("ready low while busy", 128'(rdy[d]), 128'd0);
    if (hold) begin
      g = 0;
      while (!rv[d] && g < 200) begin
        addr[d] = $urandom;
        wd[d]   = $urandom;
        wr[d]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        g++;
      end
    end
    vld[d] = 1'b0;
  endtask

  task automatic resp(input int d, input exp_t e, input logic [127:0] prev);
    check("resp cycle", 128'(cyc), 128'(e.due));
    if (e.w) check("write keeps line", line[d], prev);
    else     check("read line", line[d] & e.mask, e.line & e.mask);
  endtask

  logic [127:0] prev_a = '0;
  logic [127:0] prev_b = '0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rdy[0] && rv[0]) check("a ready with resp", 128'd1, 128'd0);
    if (rv[0]) begin
      if (q0.size() == 0) check("a unexpected resp", 128'd1, 128'd0);
      else begin
        e = q0.pop_front();
        resp(0, e, prev_a);
      end
    end
    prev_a = line[0];
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rdy[1] && rv[1]) check("b ready with resp", 128'd1, 128'd0);
    if (rv[1]) begin
      if (q1.size() == 0) check("b unexpected resp", 128'd1, 128'd0);
      else begin
        e = q1.pop_front();
        resp(1, e, prev_b);
      end
    end
    prev_b = line[1];
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, acc2, g;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; vld[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
    end
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("reset ready", 128'(rdy[d]), 128'd1);
      check("reset resp", 128'(rv[d]), 128'd0);
      check("reset line", line[d], 128'd0);
    end

    // Preload words 0..31 of both arrays; words 4..7 carry A0..A3.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        issue(d, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i - 4), 1'b0, 1'b1, acc);

    // 1: aligned line read of words 4..7
    issue(0, 1'b0, 32'h10, '0, 1'b0, 1'b1, acc);
    // 2: word write then line read sees it in word 1
    issue(0, 1'b1, 32'h24, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
    issue(0, 1'b0, 32'h20, '0, 1'b0, 1'b1, acc);
    // 3: request held and scrambled while busy
    issue(0, 1'b0, 32'h34, '0, 1'b1, 1'b1, acc);
    // 4: alias 0x1004 onto word 1
    issue(0, 1'b1, 32'h1004, 32'h0BAD_CAFE, 1'b0, 1'b1, acc);
    issue(0, 1'b0, 32'h0, '0, 1'b0, 1'b1, acc);

    // 5: reset during a write aborts it
    issue(0, 1'b1, 32'h14, 32'h1234_5678, 1'b0, 1'b0, acc);
    rstn[0] = 1'b0;
    @(posedge clk);
    #1 rstn[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    check("ready after reset", 128'(rdy[0]), 128'd1);
    check("no resp after reset", 128'(rv[0]), 128'd0);
    check("line after reset", line[0], 128'd0);
    repeat (8) @(negedge clk);
    issue(0, 1'b0, 32'h10, '0, 1'b0, 1'b1, acc);

    // 6: latency 1, back-to-back reads
    issue(1, 1'b0, 32'h0, '0, 1'b0, 1'b1, acc);
    issue(1, 1'b0, 32'h10, '0, 1'b0, 1'b1, acc2);
    check("b2b accept edge", 128'(acc2), 128'(acc + LATB + 2));

    // Random traffic inside the preloaded window, with aliasing upper bits.
    for (int n = 0; n < 80; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
      issue(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'b1, acc);
    end

    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("a queue drained", 128'(q0.size()), 128'd0);
    check("b queue drained", 128'(q1.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
